// File: rtl/bird_pkg.sv
// Shared definitions for the flappy-bird controller, physics and renderer:
// controller state encoding and common coordinate/velocity widths.
package bird_pkg;

  localparam int Y_W_DEFAULT = 10;
  localparam int VEL_W       = 6;

  typedef enum logic [2:0] {
    the_begin = 3'b100,
    bird_down = 3'b001,
    bird_up   = 3'b010,
    bird_dead = 3'b011
  } ctrl_state_e;

endpackage

// File: rtl/bird_physics_if.sv
// Bundle between the game controller (master) and the bird physics responder (slave).
interface bird_physics_if
  import bird_pkg::*;
#(
  parameter int Y_W = Y_W_DEFAULT
);

  logic [2:0]              state;
  logic [Y_W-1:0]          pipe_x;
  logic [Y_W-1:0]          gap_top;
  logic [Y_W-1:0]          gap_bot;
  logic [Y_W-1:0]          bird_y;
  logic signed [VEL_W-1:0] vel;
  logic                    dead;
  logic                    frame_tick;

  modport master (
    output state, pipe_x, gap_top, gap_bot,
    input  bird_y, vel, dead, frame_tick
  );

  modport slave (
    input  state, pipe_x, gap_top, gap_bot,
    output bird_y, vel, dead, frame_tick
  );

endinterface

// File: rtl/bird_physics_tick_gen.sv
// Frame divider: counts 0..FRAME_DIV-1 and emits a registered one-cycle tick
// FRAME_DIV cycles after reset release, then every FRAME_DIV cycles.
module tick_gen #(
  parameter int FRAME_DIV = 833333
) (
  input  logic CLK,
  input  logic RST,
  output logic tick
);

  localparam int                 CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(FRAME_DIV - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             tick_q, tick_d;

  always_comb begin
    count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    tick_d  = (count_q == LAST);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/bird_physics.sv
// Bird physics and collision responder. Stage 1 moves the bird on each frame tick,
// stage 2 evaluates collisions and strobes frame_tick. Macro BIRD_GOD_MODE_EN disables pipe hits.
module bird_physics
  import bird_pkg::*;
#(
  parameter int FRAME_DIV = 833333,
  parameter int Y_W       = Y_W_DEFAULT,
  parameter int Y_START   = 232,
  parameter int BIRD_X    = 100,
  parameter int BIRD_W    = 16,
  parameter int BIRD_H    = 16,
  parameter int PIPE_W    = 40,
  parameter int GROUND_Y  = 448,
  parameter int GRAV      = 1,
  parameter int FLAP_VEL  = 6,
  parameter int VMAX      = 8
) (
  input  logic           CLK,
  input  logic           RST,
  bird_physics_if.slave  bus
);

  localparam int N_W     = Y_W + 2;
  localparam int Y_FLOOR = GROUND_Y - BIRD_H;

  logic                    tick;
  logic [Y_W-1:0]          bird_y_q, bird_y_d;
  logic signed [VEL_W-1:0] vel_q, vel_d;
  logic                    s1_valid_q, s1_valid_d;
  logic [2:0]              s1_state_q, s1_state_d;
  logic                    dead_q, dead_d;
  logic                    frame_tick_q, frame_tick_d;

  logic signed [N_W-1:0]   y_ext, next_pos;
  logic signed [VEL_W:0]   vel_inc;
  logic                    move;
  logic [N_W-1:0]          pipe_x_ext, bird_bot;
  logic                    hit_ground, hit_pipe, x_overlap, out_of_gap;

  tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick_gen (
    .CLK  (CLK),
    .RST  (RST),
    .tick (tick)
  );

  // Stage 1: position/velocity update from the state sampled on the tick cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    bird_y_d   = bird_y_q;
    vel_d      = vel_q;
    s1_valid_d = tick;
    s1_state_d = s1_state_q;
    y_ext      = {2'b00, bird_y_q};
    next_pos   = y_ext;
    vel_inc    = (VEL_W+1)'(vel_q) + (VEL_W+1)'(GRAV);
    move       = 1'b0;

    if (tick) begin
      s1_state_d = bus.state;
      case (bus.state)
        the_begin: begin
          bird_y_d = Y_W'(Y_START);
          vel_d    = '0;
        end
        bird_down: begin
          next_pos = y_ext + N_W'(vel_q);
          move     = 1'b1;
          vel_d    = (vel_inc > (VEL_W+1)'(VMAX)) ? VEL_W'(VMAX) : VEL_W'(vel_inc);
        end
        bird_up: begin
          next_pos = y_ext - N_W'(FLAP_VEL);
          move     = 1'b1;
          vel_d    = VEL_W'(-FLAP_VEL);
        end
        default: ;
      endcase

      // Ceiling and ground clamp in the wide signed domain before narrowing.
      if (move) begin
        if (next_pos < 0)
          bird_y_d = '0;
        else if (next_pos > N_W'(Y_FLOOR))
          bird_y_d = Y_W'(Y_FLOOR);
        else
          bird_y_d = next_pos[Y_W-1:0];
      end
    end
  end

  // Stage 2: collisions against the freshly updated position.
  always_comb begin
    pipe_x_ext = {2'b00, bus.pipe_x};
    bird_bot   = {2'b00, bird_y_q} + N_W'(BIRD_H - 1);
    hit_ground = (bird_y_q >= Y_W'(Y_FLOOR));
    x_overlap  = (N_W'(BIRD_X + BIRD_W) > pipe_x_ext) &&
                 (N_W'(BIRD_X) < pipe_x_ext + N_W'(PIPE_W));
    out_of_gap = (bird_y_q < bus.gap_top) || (bird_bot > {2'b00, bus.gap_bot});
`ifdef BIRD_GOD_MODE_EN
    hit_pipe   = 1'b0;
`else
    hit_pipe   = x_overlap && out_of_gap;
`endif
    frame_tick_d = s1_valid_q;
    dead_d       = dead_q;
    if (s1_valid_q)
      dead_d = (s1_state_q == the_begin) ? 1'b0 : (dead_q | hit_ground | hit_pipe);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bird_y_q     <= Y_W'(Y_START);
      vel_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_state_q   <= the_begin;
      dead_q       <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      bird_y_q     <= bird_y_d;
      vel_q        <= vel_d;
      s1_valid_q   <= s1_valid_d;
      s1_state_q   <= s1_state_d;
      dead_q       <= dead_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.bird_y     = bird_y_q;
  assign bus.vel        = vel_q;
  assign bus.dead       = dead_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_bird_physics.sv
// Self-checking bench for bird_physics (FRAME_DIV=4): timing, vector table,
// directed corner sequences and randomized frames against a behavioural model.
module tb_bird_physics;

  localparam int FRAME_DIV = 4;
  localparam int FAR_X     = 400;
  localparam int FLOOR_Y   = 448 - 16;
  localparam int START_Y   = 232;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bird_physics_if #(.Y_W(10)) bus ();

  bird_physics #(.FRAME_DIV(FRAME_DIV)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_y   = START_Y;
  int m_vel = 0;
  bit m_dead = 1'b0;

  typedef struct {
    logic [2:0] state;
    int         px;
    int         gt;
    int         gb;
    int         exp_y;
    int         exp_vel;
    int         exp_dead;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int clamp_y(input int n);
    if (n < 0) return 0;
    if (n > FLOOR_Y) return FLOOR_Y;
    return n;
  endfunction

  function automatic bit pipe_hit(input int y, input int px, input int gt, input int gb);
`ifdef BIRD_GOD_MODE_EN
    return 1'b0;
`else
    return (100 + 16 > px) && (100 < px + 40) && ((y < gt) || (y + 15 > gb));
`endif
  endfunction

  task automatic model_step(input int s, input int px, input int gt, input int gb);
    case (s)
      4: begin m_y = START_Y; m_vel = 0; end
      1: begin
        m_y   = clamp_y(m_y + m_vel);
        m_vel = (m_vel + 1 > 8) ? 8 : m_vel + 1;
      end
      2: begin m_y = clamp_y(m_y - 6); m_vel = -6; end
      default: ;
    endcase
    if (s == 4) m_dead = 1'b0;
    else        m_dead = m_dead | (m_y >= FLOOR_Y) | pipe_hit(m_y, px, gt, gb);
  endtask

  // Drive one frame's inputs and wait for its frame_tick (bounded).
  task automatic do_frame(input int s, input int px, input int gt, input int gb);
    bit seen;
    seen        = 1'b0;
    bus.state   = 3'(s);
    bus.pipe_x  = 10'(px);
    bus.gap_top = 10'(gt);
    bus.gap_bot = 10'(gb);
    for (int i = 0; i < 4 * FRAME_DIV; i++) begin
      @(negedge clk);
      if (bus.frame_tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("frame_tick_seen", int'(seen), 1);
    model_step(s, px, gt, gb);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_y"},    int'(bus.bird_y), m_y);
    check({tag, "_vel"},  int'(bus.vel),    m_vel);
    check({tag, "_dead"}, int'(bus.dead),   int'(m_dead));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_y"},    int'(bus.bird_y),     START_Y);
    check({tag, "_vel"},  int'(bus.vel),        0);
    check({tag, "_dead"}, int'(bus.dead),       0);
    check({tag, "_ft"},   int'(bus.frame_tick), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{3'b100, FAR_X, 0,   479, 232,  0, 0};
    vecs[1] = '{3'b001, FAR_X, 0,   479, 232,  1, 0};
    vecs[2] = '{3'b001, FAR_X, 0,   479, 233,  2, 0};
    vecs[3] = '{3'b001, FAR_X, 0,   479, 235,  3, 0};
    vecs[4] = '{3'b001, FAR_X, 0,   479, 238,  4, 0};
    vecs[5] = '{3'b010, FAR_X, 0,   479, 232, -6, 0};
    vecs[6] = '{3'b001, FAR_X, 0,   479, 226, -5, 0};
    vecs[7] = '{3'b100, FAR_X, 0,   479, 232,  0, 0};
    vecs[8] = '{3'b011, 100,   200, 260, 232,  0, 0};
    vecs[9] = '{3'b001, FAR_X, 0,   479, 232,  1, 0};

    // Reset and frame timing
    bus.state   = 3'b100;
    bus.pipe_x  = 10'(FAR_X);
    bus.gap_top = 10'd0;
    bus.gap_bot = 10'd479;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_values("reset");
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      check($sformatf("ft_cycle%0d", c), int'(bus.frame_tick),
            int'(c == 6 || c == 10 || c == 14));
    end
    check("begin_y", int'(bus.bird_y), START_Y);

    // Vector table: gravity, flap, pipe inside gap
    for (int i = 0; i < 10; i++) begin
      do_frame(vecs[i].state, vecs[i].px, vecs[i].gt, vecs[i].gb);
      check($sformatf("vec%0d_y", i),    int'(bus.bird_y), vecs[i].exp_y);
      check($sformatf("vec%0d_vel", i),  int'(bus.vel),    vecs[i].exp_vel);
      check($sformatf("vec%0d_dead", i), int'(bus.dead),   vecs[i].exp_dead);
      @(negedge clk);
      check($sformatf("vec%0d_ft_width", i), int'(bus.frame_tick), 0);
    end

    // Ceiling: flap to the top, then one more flap clamps at 0
    do_frame(4, FAR_X, 0, 479);
    for (int i = 0; i < 60 && m_y >= 6; i++) begin
      do_frame(2, FAR_X, 0, 479);
      check_model("climb");
    end
    do_frame(2, FAR_X, 0, 479);
    check("ceil_y",    int'(bus.bird_y), 0);
    check("ceil_vel",  int'(bus.vel),    -6);
    check("ceil_dead", int'(bus.dead),   0);

    // Pipe: y=190 is above the gap
    do_frame(4, FAR_X, 0, 479);
    for (int i = 0; i < 7; i++) do_frame(2, FAR_X, 0, 479);
    check("pipe_setup_y", int'(bus.bird_y), 190);
    do_frame(3, 100, 200, 260);
    check("pipe_hold_y", int'(bus.bird_y), 190);
`ifdef BIRD_GOD_MODE_EN
    check("pipe_dead", int'(bus.dead), 0);
`else
    check("pipe_dead", int'(bus.dead), 1);
`endif
    do_frame(4, 100, 200, 260);
    check("pipe_begin_clears", int'(bus.dead), 0);

    // Gravity to the ground with velocity saturation
    for (int i = 0; i < 80 && m_y < FLOOR_Y; i++) begin
      do_frame(1, FAR_X, 0, 479);
      check_model("fall");
      check("vel_le_vmax", int'(int'(bus.vel) <= 8), 1);
    end
    check("ground_y",    int'(bus.bird_y), FLOOR_Y);
    check("ground_vel",  int'(bus.vel),    8);
    check("ground_dead", int'(bus.dead),   1);
    do_frame(3, FAR_X, 0, 479);
    check("dead_hold_y",    int'(bus.bird_y), FLOOR_Y);
    check("dead_hold_dead", int'(bus.dead),   1);

    // Mid-frame reset: assert after stage 1 of an in-flight frame
    bus.state = 3'b001;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    bus.state = 3'b100;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_y = START_Y; m_vel = 0; m_dead = 1'b0;
    check_reset_values("midrst_rel");
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check($sformatf("midrst_ft_cycle%0d", c), int'(bus.frame_tick), int'(c == 6));
    end
    model_step(4, FAR_X, 0, 479);
    check_model("after_midrst");

    // Randomized frames against the model
    for (int i = 0; i < 60; i++) begin
      int r, s, px, gt, gb;
      r  = int'($urandom_range(0, 9));
      if (r <= 1)      s = 4;
      else if (r <= 4) s = 1;
      else if (r <= 6) s = 2;
      else if (r == 7) s = 3;
      else             s = int'($urandom_range(0, 7));
      px = int'($urandom_range(0, 700));
      gt = int'($urandom_range(0, 450));
      gb = int'($urandom_range(gt, 479));
      do_frame(s, px, gt, gb);
      check_model($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
